// File: rtl/aes_pkg.sv
// Shared AES constants: block/byte widths, FIPS-197 forward and inverse
// S-box tables, and the SubBytes engine state encoding.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte combinational S-box lane. With INV_EN=0 only the forward
// table is built and the inv select has no effect.
module aes_sbox_byte
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [BYTE_W-1:0] din,
  input  logic              inv,
  output logic [BYTE_W-1:0] dout
);

  if (INV_EN) begin : g_fwd_inv
    assign dout = inv ? INV_SBOX[din] : SBOX[din];
  end else begin : g_fwd_only
    logic unused_inv;
    assign unused_inv = inv;
    assign dout       = SBOX[din];
  end

endmodule

// File: rtl/subbytes_engine.sv
// Iterative AES SubBytes/InvSubBytes engine: one 128-bit state per
// handshake, LANES bytes substituted per clock through shared S-box lanes.
module subbytes_engine
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t              st;
  logic [0:BLOCK_W-1]  blk_q;
  logic [0:BLOCK_W-1]  blk_sub;
  logic [CNT_W-1:0]    cnt;
  logic                mode_q;
  logic                accept;
  logic [BYTE_W-1:0]   lane_in  [LANES];
  logic [BYTE_W-1:0]   lane_out [LANES];

  assign accept    = in_valid && in_ready;
  assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);
  assign out_data  = blk_q;

  // Select the bytes of the current beat onto the S-box lanes.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = blk_q[7'((int'(cnt) * LANES + int'(l)) * BYTE_W) +: BYTE_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_byte #(
      .INV_EN(INV_EN)
    ) u_sbox (
      .din (lane_in[g]),
      .inv (mode_q),
      .dout(lane_out[g])
    );
  end

  // Merge the substituted beat back into the full state.
  always_comb begin
    blk_sub = blk_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      blk_sub[7'((int'(cnt) * LANES + int'(l)) * BYTE_W) +: BYTE_W] = lane_out[l];
    end
  end

  // Handshake FSM and state register; DONE re-enters SUB directly on a same-cycle swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      blk_q  <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (accept) begin
            blk_q  <= in_data;
            mode_q <= in_inv && INV_EN;
            cnt    <= '0;
            st     <= SUB;
          end
        end
        SUB: begin
          blk_q <= blk_sub;
          if (cnt == LAST_BEAT) begin
            cnt <= '0;
            st  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              blk_q  <= in_data;
              mode_q <= in_inv && INV_EN;
              cnt    <= '0;
              st     <= SUB;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/subbytes_engine.md
Name: subbytes_engine

Overview:
Iterative, parametrised AES SubBytes/InvSubBytes engine. It accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per clock through LANES shared S-box lanes, in forward or inverse mode. The result is presented on a second valid/ready handshake. It sits between the round-key/ShiftRows stages of the AES datapath and trades area for latency via LANES.

Parameters:
LANES, 4, S-box lanes used per cycle; legal values 1, 2, 4, 8, 16; BEATS = 16/LANES.
INV_EN, 1, 1 = inverse S-box instantiated and in_inv honoured; 0 = forward only, in_inv ignored.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input state valid.
in_ready  output  1  engine can accept a state.
in_data  input  [0:127]  input state; byte k = bits [8k:8k+7], byte 0 first.
in_inv  input  1  1 = InvSubBytes, 0 = SubBytes; sampled with in_data.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  [0:127]  substituted state, same byte ordering as in_data.
busy  output  1  high in SUB and DONE.

Behaviour:
- Reset and clock: one clock, clk. rst is synchronous and active-high. On rst: state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, beat counter=0, latched mode=0. A reset mid-operation aborts the block in flight; no partial result is ever presented.
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the state register, latch mode (in_inv&&INV_EN), clear the counter, go to SUB.
- SUB: in_ready=0. Each cycle, replace bytes [cnt*LANES .. cnt*LANES+LANES-1] with S(byte) or S^-1(byte); cnt increments.
  - When cnt==BEATS-1, that beat completes and the FSM goes to DONE next cycle; cnt wraps to 0.
  - in_valid is ignored in SUB.
- DONE: out_valid=1, out_data = state register, held stable until out_ready.
  - in_ready = out_ready (back-to-back accept).
  - out_ready=1, in_valid=1: result and new input transfer in the same cycle; go straight to SUB with the new data and mode.
  - out_ready=1, in_valid=0: go to IDLE.
  - out_ready=0: remain in DONE, all outputs held.
- Latency: input handshake at cycle T gives out_valid at T+BEATS+1 (LANES=16: T+2). Sustained throughput is one block per BEATS+1 cycles.
- Byte ordering: every byte, including bytes 1..15, is indexed identically ([8k:8k+7] → [8k:8k+7]). No per-byte exceptions.
- out_data is registered only; it does not change while out_valid=1 and out_ready=0.
- in_inv with INV_EN=0 yields the forward result.

Decomposition:
- Shared package aes_pkg:
  - BLOCK_W=128, BYTE_W=8.
  - Constant arrays SBOX[0:255] and INV_SBOX[0:255] (FIPS-197).
  - State enum {IDLE, SUB, DONE}.
- Sub-module aes_sbox_byte:
  - Combinational 8-bit lookup with an inv select.
  - Parameter INV_EN drops the inverse table when 0.
  - Instantiated LANES times, driven by a per-beat byte multiplexer.

Test Plan:
1. LANES=16, forward: in_data = 193de3bea0f4e22b9ac68d2ae9f84808 → out_data = d42711aee0bf98f1b8b45de51e415230, with out_valid exactly 2 cycles after accept.
2. LANES=1, inverse: in_data = d42711aee0bf98f1b8b45de51e415230 with in_inv=1 → out_data = 193de3bea0f4e22b9ac68d2ae9f84808, out_valid at cycle 17. Also in_data = all 0x63, in_inv=1 → all 0x00.
3. LANES=4, backpressure: hold out_ready=0 for 10 cycles with in_valid=1 → out_data stable, in_ready=0. Then raise out_ready with a new input 00112233445566778899aabbccddeeff → same-cycle transfer; next result = 638293c31bfc33f5c4eeacea4bc12816 at accept+5.
4. Reset mid-SUB: assert rst for one cycle at beat 2 of LANES=2 → next cycle out_valid=0, in_ready=1, out_data=0, busy=0. A following block completes correctly.
5. INV_EN=0: in_data = all 0x00, in_inv=1 → out_data = all 0x63.
6. Boundary bytes: in_data bytes 0..15 = 00,01,…,0e,ff → out_data = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 16, checking every byte position independently (especially bytes 1 and 15).
